// File: rtl/udp_roce_connection_manager_tx_64.sv
// -----------------------------------------------------------------------------
// udp_roce_connection_manager_tx_64
//
// Purpose:
//   Transmit side of the RoCE connection-manager exchange. Accepts one
//   QP-info / tx-metadata request and emits a UDP header followed by a 44-byte
//   payload (6 beats of 64-bit AXI-stream) toward the UDP stack. The remote
//   peer's connection manager decodes this payload.
//
// Ports (summary):
//   clk, rst                  clock, synchronous active-high reset
//   s_req_*                   request handshake and fields (latched on accept)
//   s_dest_ip, s_source_ip    IP header addresses for the frame
//   m_udp_hdr_* / m_ip_*      UDP/IP header channel (valid/ready)
//   m_udp_payload_axis_*      64-bit payload stream, 6 beats, last beat 4 bytes
//   busy                      high while a frame is in flight
//   frame_count               completed frames, wraps at 16 bits
//
// Payload byte n travels in beat n/8 at tdata[8(n%8)+7 : 8(n%8)].
// Multi-byte fields are big-endian (MS byte at the lowest byte index).
// -----------------------------------------------------------------------------
module udp_roce_connection_manager_tx_64 #(
    parameter logic [15:0] DEST_UDP_PORT = 16'h4321,
    parameter logic [15:0] SRC_UDP_PORT  = 16'h4321,
    parameter logic [7:0]  IP_TTL        = 8'd64
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        s_req_valid,
    output logic        s_req_ready,
    input  logic        s_qp_info_valid,
    input  logic [23:0] s_rem_qpn,
    input  logic [23:0] s_loc_qpn,
    input  logic [23:0] s_rem_psn,
    input  logic [23:0] s_loc_psn,
    input  logic [31:0] s_r_key,
    input  logic [63:0] s_rem_base_addr,
    input  logic        s_txmeta_valid,
    input  logic        s_txmeta_start,
    input  logic        s_txmeta_write_type,
    input  logic [31:0] s_txmeta_rem_ip_addr,
    input  logic [63:0] s_txmeta_rem_addr_offset,
    input  logic [31:0] s_txmeta_dma_length,
    input  logic [15:0] s_txmeta_rem_udp_port,
    input  logic [31:0] s_dest_ip,
    input  logic [31:0] s_source_ip,

    output logic        m_udp_hdr_valid,
    input  logic        m_udp_hdr_ready,
    output logic [5:0]  m_ip_dscp,
    output logic [1:0]  m_ip_ecn,
    output logic [7:0]  m_ip_ttl,
    output logic [31:0] m_ip_source_ip,
    output logic [31:0] m_ip_dest_ip,
    output logic [15:0] m_udp_source_port,
    output logic [15:0] m_udp_dest_port,
    output logic [15:0] m_udp_length,
    output logic [15:0] m_udp_checksum,

    output logic [63:0] m_udp_payload_axis_tdata,
    output logic [7:0]  m_udp_payload_axis_tkeep,
    output logic        m_udp_payload_axis_tvalid,
    input  logic        m_udp_payload_axis_tready,
    output logic        m_udp_payload_axis_tlast,
    output logic        m_udp_payload_axis_tuser,

    output logic        busy,
    output logic [15:0] frame_count
);

    localparam int PAYLOAD_BYTES = 44;
    localparam int PAYLOAD_BITS  = PAYLOAD_BYTES * 8;   // 352
    localparam logic [2:0] LAST_BEAT = 3'd5;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    logic [1:0]              r_state;
    logic                    r_req_ready;
    logic                    r_hdr_valid;
    logic                    r_tvalid;
    logic [2:0]              r_beat;
    logic [15:0]             r_frame_count;
    logic [PAYLOAD_BITS-1:0] r_payload;
    logic [31:0]             r_dest_ip;
    logic [31:0]             r_source_ip;

    logic [PAYLOAD_BITS-1:0] w_payload_be;
    logic [PAYLOAD_BITS-1:0] w_payload_le;
    logic [383:0]            w_payload_padded;
    logic                    w_req_fire;
    logic                    w_hdr_fire;
    logic                    w_beat_fire;

    // Field concatenation puts byte 0 in the most significant position, which
    // directly gives big-endian order inside every field.
    assign w_payload_be = {
        7'b0, s_qp_info_valid,
        s_rem_qpn, s_loc_qpn, s_rem_psn, s_loc_psn,
        s_r_key, s_rem_base_addr,
        5'b0, s_txmeta_write_type, s_txmeta_start, s_txmeta_valid,
        s_txmeta_rem_ip_addr, s_txmeta_rem_addr_offset,
        s_txmeta_dma_length, s_txmeta_rem_udp_port
    };

    // Reverse byte order so that byte n lands at bits [8n+7:8n]; the stream
    // beat is then a plain 64-bit slice of the shadow register.
    generate
        for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_byte_swap
            assign w_payload_le[8*gi +: 8] = w_payload_be[8*(PAYLOAD_BYTES-1-gi) +: 8];
        end
    endgenerate

    assign w_req_fire  = s_req_valid && r_req_ready;
    assign w_hdr_fire  = r_hdr_valid && m_udp_hdr_ready;
    assign w_beat_fire = r_tvalid && m_udp_payload_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b0;
            r_hdr_valid   <= 1'b0;
            r_tvalid      <= 1'b0;
            r_beat        <= 3'd0;
            r_frame_count <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Ready comes up one cycle after reset release and stays up
                    // until a request is taken.
                    r_req_ready <= 1'b1;
                    if (w_req_fire) begin
                        r_req_ready <= 1'b0;
                        r_hdr_valid <= 1'b1;
                        r_state     <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (w_hdr_fire) begin
                        r_hdr_valid <= 1'b0;
                        r_tvalid    <= 1'b1;
                        r_beat      <= 3'd0;
                        r_state     <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_beat_fire) begin
                        if (r_beat == LAST_BEAT) begin
                            r_tvalid      <= 1'b0;
                            r_beat        <= 3'd0;
                            r_req_ready   <= 1'b1;
                            r_frame_count <= r_frame_count + 16'd1;
                            r_state       <= ST_IDLE;
                        end else begin
                            r_beat <= r_beat + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b0;
                    r_hdr_valid <= 1'b0;
                    r_tvalid    <= 1'b0;
                end
            endcase
        end
    end

    // Shadow registers carry no reset: they are only observed while a valid
    // is asserted, and they are always loaded before that happens.
    always_ff @(posedge clk) begin
        if (w_req_fire && (r_state == ST_IDLE)) begin
            r_payload   <= w_payload_le;
            r_dest_ip   <= s_dest_ip;
            r_source_ip <= s_source_ip;
        end
    end

    // The last beat holds only bytes 40..43; the upper half reads as zero.
    assign w_payload_padded = {32'b0, r_payload};

    assign s_req_ready       = r_req_ready;
    assign m_udp_hdr_valid   = r_hdr_valid;
    assign m_ip_dscp         = 6'd0;
    assign m_ip_ecn          = 2'd0;
    assign m_ip_ttl          = IP_TTL;
    assign m_ip_source_ip    = r_source_ip;
    assign m_ip_dest_ip      = r_dest_ip;
    assign m_udp_source_port = SRC_UDP_PORT;
    assign m_udp_dest_port   = DEST_UDP_PORT;
    assign m_udp_length      = 16'd52;      // 8-byte UDP header + 44-byte payload
    assign m_udp_checksum    = 16'd0;

    assign m_udp_payload_axis_tdata  = w_payload_padded[{r_beat, 6'b0} +: 64];
    assign m_udp_payload_axis_tkeep  = (r_beat == LAST_BEAT) ? 8'h0F : 8'hFF;
    assign m_udp_payload_axis_tlast  = (r_beat == LAST_BEAT);
    assign m_udp_payload_axis_tvalid = r_tvalid;
    assign m_udp_payload_axis_tuser  = 1'b0;

    assign busy        = (r_state != ST_IDLE);
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_udp_roce_connection_manager_tx_64.sv
// -----------------------------------------------------------------------------
// Testbench for udp_roce_connection_manager_tx_64.
// Expected payload beats come from a byte-array model filled straight from the
// payload layout rules; each check is an immediate assertion.
// -----------------------------------------------------------------------------
module tb_udp_roce_connection_manager_tx_64;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_req_valid;
    logic        s_req_ready;
    logic        s_qp_info_valid;
    logic [23:0] s_rem_qpn, s_loc_qpn, s_rem_psn, s_loc_psn;
    logic [31:0] s_r_key;
    logic [63:0] s_rem_base_addr;
    logic        s_txmeta_valid, s_txmeta_start, s_txmeta_write_type;
    logic [31:0] s_txmeta_rem_ip_addr;
    logic [63:0] s_txmeta_rem_addr_offset;
    logic [31:0] s_txmeta_dma_length;
    logic [15:0] s_txmeta_rem_udp_port;
    logic [31:0] s_dest_ip, s_source_ip;
    logic        m_udp_hdr_valid;
    logic        m_udp_hdr_ready;
    logic [5:0]  m_ip_dscp;
    logic [1:0]  m_ip_ecn;
    logic [7:0]  m_ip_ttl;
    logic [31:0] m_ip_source_ip, m_ip_dest_ip;
    logic [15:0] m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum;
    logic [63:0] m_udp_payload_axis_tdata;
    logic [7:0]  m_udp_payload_axis_tkeep;
    logic        m_udp_payload_axis_tvalid;
    logic        m_udp_payload_axis_tready;
    logic        m_udp_payload_axis_tlast;
    logic        m_udp_payload_axis_tuser;
    logic        busy;
    logic [15:0] frame_count;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_count;
    logic [63:0] exp_beat [6];
    logic [31:0] exp_dest_ip, exp_source_ip;

    always #5 clk = ~clk;

    udp_roce_connection_manager_tx_64 dut (
        .clk(clk), .rst(rst),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_qp_info_valid(s_qp_info_valid),
        .s_rem_qpn(s_rem_qpn), .s_loc_qpn(s_loc_qpn),
        .s_rem_psn(s_rem_psn), .s_loc_psn(s_loc_psn),
        .s_r_key(s_r_key), .s_rem_base_addr(s_rem_base_addr),
        .s_txmeta_valid(s_txmeta_valid), .s_txmeta_start(s_txmeta_start),
        .s_txmeta_write_type(s_txmeta_write_type),
        .s_txmeta_rem_ip_addr(s_txmeta_rem_ip_addr),
        .s_txmeta_rem_addr_offset(s_txmeta_rem_addr_offset),
        .s_txmeta_dma_length(s_txmeta_dma_length),
        .s_txmeta_rem_udp_port(s_txmeta_rem_udp_port),
        .s_dest_ip(s_dest_ip), .s_source_ip(s_source_ip),
        .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
        .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn), .m_ip_ttl(m_ip_ttl),
        .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
        .m_udp_source_port(m_udp_source_port), .m_udp_dest_port(m_udp_dest_port),
        .m_udp_length(m_udp_length), .m_udp_checksum(m_udp_checksum),
        .m_udp_payload_axis_tdata(m_udp_payload_axis_tdata),
        .m_udp_payload_axis_tkeep(m_udp_payload_axis_tkeep),
        .m_udp_payload_axis_tvalid(m_udp_payload_axis_tvalid),
        .m_udp_payload_axis_tready(m_udp_payload_axis_tready),
        .m_udp_payload_axis_tlast(m_udp_payload_axis_tlast),
        .m_udp_payload_axis_tuser(m_udp_payload_axis_tuser),
        .busy(busy), .frame_count(frame_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: lay the fields out as a byte array, then pack beats.
    task automatic build_expected();
        logic [7:0] b [48];
        for (int i = 0; i < 48; i++) b[i] = 8'h00;
        b[0] = {7'b0, s_qp_info_valid};
        for (int k = 0; k < 3; k++) begin
            b[1 + k]  = 8'((s_rem_qpn >> (8 * (2 - k))) & 24'hFF);
            b[4 + k]  = 8'((s_loc_qpn >> (8 * (2 - k))) & 24'hFF);
            b[7 + k]  = 8'((s_rem_psn >> (8 * (2 - k))) & 24'hFF);
            b[10 + k] = 8'((s_loc_psn >> (8 * (2 - k))) & 24'hFF);
        end
        for (int k = 0; k < 4; k++) begin
            b[13 + k] = 8'((s_r_key >> (8 * (3 - k))) & 32'hFF);
            b[26 + k] = 8'((s_txmeta_rem_ip_addr >> (8 * (3 - k))) & 32'hFF);
            b[38 + k] = 8'((s_txmeta_dma_length >> (8 * (3 - k))) & 32'hFF);
        end
        for (int k = 0; k < 8; k++) begin
            b[17 + k] = 8'((s_rem_base_addr >> (8 * (7 - k))) & 64'hFF);
            b[30 + k] = 8'((s_txmeta_rem_addr_offset >> (8 * (7 - k))) & 64'hFF);
        end
        b[25] = {5'b0, s_txmeta_write_type, s_txmeta_start, s_txmeta_valid};
        b[42] = s_txmeta_rem_udp_port[15:8];
        b[43] = s_txmeta_rem_udp_port[7:0];
        for (int i = 0; i < 6; i++) begin
            exp_beat[i] = 64'd0;
            for (int j = 0; j < 8; j++)
                exp_beat[i] = exp_beat[i] | (64'(b[8 * i + j]) << (8 * j));
        end
        exp_dest_ip   = s_dest_ip;
        exp_source_ip = s_source_ip;
    endtask

    task automatic randomize_fields();
        logic [31:0] t;
        t = $urandom; s_qp_info_valid = t[0]; s_txmeta_valid = t[1];
        s_txmeta_start = t[2]; s_txmeta_write_type = t[3];
        t = $urandom; s_rem_qpn = t[23:0];
        t = $urandom; s_loc_qpn = t[23:0];
        t = $urandom; s_rem_psn = t[23:0];
        t = $urandom; s_loc_psn = t[23:0];
        s_r_key = $urandom;
        s_rem_base_addr = {$urandom, $urandom};
        s_txmeta_rem_ip_addr = $urandom;
        s_txmeta_rem_addr_offset = {$urandom, $urandom};
        s_txmeta_dma_length = $urandom;
        t = $urandom; s_txmeta_rem_udp_port = t[15:0];
        s_dest_ip = $urandom;
        s_source_ip = $urandom;
    endtask

    // One frame. Fields must already be on the inputs. hdr_stall: hdr_ready
    // low cycles; pay_mode 0=always ready, 1=1010 toggle, 2=random;
    // keep_valid leaves s_req_valid high with scrambled fields afterwards;
    // abort_beat >= 0 applies reset while that beat is presented.
    task automatic run_frame(input string name, input int hdr_stall, input int pay_mode,
                             input bit keep_valid, input int abort_beat);
        int n;
        int got;
        logic [31:0] r;
        build_expected();
        s_req_valid = 1'b1;
        n = 0;
        while (!s_req_ready && n < 50) begin @(negedge clk); n++; end
        chk({name, ":req_ready"}, 64'(s_req_ready), 64'd1);
        @(negedge clk);     // request taken on the edge just passed
        if (keep_valid) randomize_fields();
        else s_req_valid = 1'b0;
        chk({name, ":ready_drop"}, 64'(s_req_ready), 64'd0);
        chk({name, ":busy"}, 64'(busy), 64'd1);
        for (int i = 0; i <= hdr_stall; i++) begin
            chk({name, ":hdr_valid"}, 64'(m_udp_hdr_valid), 64'd1);
            chk({name, ":no_tvalid_hdr"}, 64'(m_udp_payload_axis_tvalid), 64'd0);
            chk({name, ":hdr_ips"}, {m_ip_dest_ip, m_ip_source_ip}, {exp_dest_ip, exp_source_ip});
            chk({name, ":hdr_ports"}, {m_udp_dest_port, m_udp_source_port, m_udp_length, m_udp_checksum},
                {16'h4321, 16'h4321, 16'd52, 16'd0});
            chk({name, ":hdr_misc"}, {m_ip_ttl, m_ip_dscp, m_ip_ecn}, {8'd64, 6'd0, 2'd0});
            m_udp_hdr_ready = (i == hdr_stall);
            @(negedge clk);
        end
        m_udp_hdr_ready = 1'b0;
        chk({name, ":hdr_done"}, 64'(m_udp_hdr_valid), 64'd0);
        got = 0;
        n = 0;
        while (got < 6 && n < 60) begin
            if (m_udp_payload_axis_tvalid) begin
                chk({name, ":tdata"}, m_udp_payload_axis_tdata, exp_beat[got]);
                chk({name, ":tkeep_tlast"}, {m_udp_payload_axis_tkeep, 7'd0, m_udp_payload_axis_tlast},
                    (got == 5) ? {8'h0F, 8'h01} : {8'hFF, 8'h00});
            end
            if (got == abort_beat && m_udp_payload_axis_tvalid) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk({name, ":abort_tvalid"}, 64'(m_udp_payload_axis_tvalid), 64'd0);
                chk({name, ":abort_hdr"}, 64'(m_udp_hdr_valid), 64'd0);
                exp_count = 16'd0;
                chk({name, ":abort_count"}, 64'(frame_count), 64'(exp_count));
                return;
            end
            case (pay_mode)
                0: m_udp_payload_axis_tready = 1'b1;
                1: m_udp_payload_axis_tready = (n % 2 == 0);
                default: begin r = $urandom; m_udp_payload_axis_tready = r[0]; end
            endcase
            if (m_udp_payload_axis_tvalid && m_udp_payload_axis_tready) got++;
            @(negedge clk);
            n++;
        end
        m_udp_payload_axis_tready = 1'b0;
        chk({name, ":beats"}, 64'(got), 64'd6);
        exp_count = exp_count + 16'd1;
        chk({name, ":end_tvalid"}, 64'(m_udp_payload_axis_tvalid), 64'd0);
        chk({name, ":end_ready"}, 64'(s_req_ready), 64'd1);
        chk({name, ":end_busy"}, 64'(busy), 64'd0);
        chk({name, ":frame_count"}, 64'(frame_count), 64'(exp_count));
    endtask

    initial begin
        rst = 1'b1;
        s_req_valid = 1'b0;
        m_udp_hdr_ready = 1'b0;
        m_udp_payload_axis_tready = 1'b0;
        randomize_fields();
        exp_count = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset:ready", 64'(s_req_ready), 64'd0);
        chk("reset:valids", {m_udp_hdr_valid, m_udp_payload_axis_tvalid, m_udp_payload_axis_tlast, busy},
            64'd0);
        chk("reset:count", 64'(frame_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset:ready", 64'(s_req_ready), 64'd1);

        // Directed frame with known field values.
        s_qp_info_valid = 1'b1; s_rem_qpn = 24'h123456; s_loc_qpn = 24'hABCDEF;
        s_rem_psn = 24'h000001; s_loc_psn = 24'h000002; s_r_key = 32'hDEADBEEF;
        s_rem_base_addr = 64'h0011223344556677; s_txmeta_valid = 1'b1;
        s_txmeta_start = 1'b1; s_txmeta_write_type = 1'b0;
        s_txmeta_rem_ip_addr = 32'h0A000001; s_txmeta_rem_addr_offset = 64'h10;
        s_txmeta_dma_length = 32'h00001000; s_txmeta_rem_udp_port = 16'h12B7;
        s_dest_ip = 32'hC0A80002; s_source_ip = 32'hC0A80001;
        build_expected();
        chk("model:beat5", exp_beat[5], 64'h00000000B7120010);
        run_frame("directed", 0, 0, 1'b0, -1);

        // Header backpressure.
        randomize_fields();
        run_frame("hdr_stall", 5, 0, 1'b0, -1);

        // Payload backpressure with toggling ready, then random ready.
        randomize_fields();
        run_frame("toggle", 0, 1, 1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            randomize_fields();
            run_frame("random", i, 2, 1'b0, -1);
        end

        // Back-to-back: valid held high, inputs scrambled while busy.
        randomize_fields();
        run_frame("b2b_first", 0, 0, 1'b1, -1);
        randomize_fields();
        run_frame("b2b_second", 1, 2, 1'b0, -1);

        // Reset during beat 3, then a clean frame.
        randomize_fields();
        run_frame("abort", 0, 0, 1'b0, 3);
        @(negedge clk);
        randomize_fields();
        run_frame("after_abort", 0, 0, 1'b0, -1);

        // Counter wrap.
        force dut.r_frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_count;
        exp_count = 16'hFFFF;
        randomize_fields();
        run_frame("wrap", 0, 0, 1'b0, -1);
        chk("wrap:zero", 64'(frame_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
